// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg -- shared definitions for the floating-point register file slice.
//   FLEN          : width of one FP register (IEEE754 single)
//   NREG          : number of FP registers f0..f31 (no hardwired zero)
//   CNT_W         : width of the busy population count (holds 0..NREG)
//   fp_reg_addr_t : 5-bit register address
//   fp_word_t     : FLEN-bit register word
//   busy_popcount : number of set bits in a busy vector
// Related build macro: FP_REG_BYPASS_EN (used by fp_regfile / fp_scoreboard).
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int FLEN  = 32;
    localparam int NREG  = 32;
    localparam int CNT_W = $clog2(NREG + 1);

    typedef logic [4:0]      fp_reg_addr_t;
    typedef logic [FLEN-1:0] fp_word_t;

    // Population count of the busy vector; CNT_W bits are enough for NREG.
    function automatic logic [CNT_W-1:0] busy_popcount(input logic [NREG-1:0] bits);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// -----------------------------------------------------------------------------
// fp_scoreboard -- per-register busy tracking and RAW hazard detection.
//   clk, rst_n          : clock, synchronous active-low reset
//   iss_en, iss_rd      : op issued this cycle, marks iss_rd busy
//   wb_en, wb_addr      : writeback this cycle, clears wb_addr busy
//   flush               : drop every pending producer (issue same cycle ignored)
//   rs1_addr, rs1_use   : source 1 address / source 1 actually read
//   rs2_addr, rs2_use   : source 2 address / source 2 actually read
//   stall               : combinational hazard request to hold decode
//   busy_cnt            : registered count of busy registers
// Build macro FP_REG_BYPASS_EN: a same-cycle writeback to a source removes
// its hazard; without it the hazard stays until the cycle after the write.
// -----------------------------------------------------------------------------
module fp_scoreboard
    import fp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iss_en,
    input  logic [4:0]         iss_rd,
    input  logic               wb_en,
    input  logic [4:0]         wb_addr,
    input  logic               flush,
    input  logic [4:0]         rs1_addr,
    input  logic               rs1_use,
    input  logic [4:0]         rs2_addr,
    input  logic               rs2_use,
    output logic               stall,
    output logic [CNT_W-1:0]   busy_cnt
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_next_s;
    logic [NREG-1:0] wb_mask_s;
    logic [NREG-1:0] iss_mask_s;
    logic            hazard1_s;
    logic            hazard2_s;

    // One-hot masks for the writeback clear and the issue set.
    always_comb begin
        wb_mask_s  = {NREG{1'b0}};
        iss_mask_s = {NREG{1'b0}};
        if (wb_en) begin
            wb_mask_s[wb_addr] = 1'b1;
        end else begin
            wb_mask_s = {NREG{1'b0}};
        end
        // A flush cancels the issue of the same cycle.
        if (iss_en && !flush) begin
            iss_mask_s[iss_rd] = 1'b1;
        end else begin
            iss_mask_s = {NREG{1'b0}};
        end
    end

    // Next busy state: set applied after clear so a newer producer survives
    // a same-register writeback; flush empties the whole table.
    always_comb begin
        busy_next_s = busy_r;
        if (flush) begin
            busy_next_s = {NREG{1'b0}};
        end else begin
            busy_next_s = (busy_r & ~wb_mask_s) | iss_mask_s;
        end
    end

`ifdef FP_REG_BYPASS_EN
    // The writeback value is forwarded, so a matching source is satisfied now.
    assign hazard1_s = busy_r[rs1_addr] & ~(wb_en & (wb_addr == rs1_addr));
    assign hazard2_s = busy_r[rs2_addr] & ~(wb_en & (wb_addr == rs2_addr));
`else
    // No forwarding: the source waits until the array holds the new value.
    assign hazard1_s = busy_r[rs1_addr];
    assign hazard2_s = busy_r[rs2_addr];
`endif

    assign stall = (rs1_use & hazard1_s) | (rs2_use & hazard2_s);

    // Busy bits and their count update on the same edge; reset drops all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r   <= {NREG{1'b0}};
            busy_cnt <= {CNT_W{1'b0}};
        end else begin
            busy_r   <= busy_next_s;
            busy_cnt <= busy_popcount(busy_next_s);
        end
    end

endmodule

// File: rtl/fp_regfile.sv
// -----------------------------------------------------------------------------
// fp_regfile -- 32 x FLEN floating-point register file with a busy scoreboard.
//   clk, rst_n          : clock, synchronous active-low reset (clears array)
//   rs1_addr, rs2_addr  : combinational read addresses (FP adder A / B)
//   rs1_use, rs2_use    : source actually read by the decoded op
//   rs1_data, rs2_data  : read data
//   wb_en, wb_addr, wb_data : single writeback port
//   iss_en, iss_rd      : FP op issued this cycle that will write iss_rd
//   flush               : cancel all in-flight FP ops
//   stall               : RAW hazard request
//   busy_cnt            : number of busy registers (0..32)
// Build macro FP_REG_BYPASS_EN: when defined, a same-cycle writeback is
// forwarded to a matching read port.
// -----------------------------------------------------------------------------
module fp_regfile #(
    parameter int FLEN = fp_pkg::FLEN,
    parameter int NREG = fp_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    input  logic            rs1_use,
    input  logic            rs2_use,
    output logic [FLEN-1:0] rs1_data,
    output logic [FLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [FLEN-1:0] wb_data,
    input  logic            iss_en,
    input  logic [4:0]      iss_rd,
    input  logic            flush,
    output logic            stall,
    output logic [5:0]      busy_cnt
);
    import fp_pkg::*;

    logic [FLEN-1:0] regs_r [NREG];
    fp_reg_addr_t    rs1_idx_s;
    fp_reg_addr_t    rs2_idx_s;

    assign rs1_idx_s = rs1_addr;
    assign rs2_idx_s = rs2_addr;

    // Register array: reset clears everything and beats a pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {FLEN{1'b0}};
            end
        end else if (wb_en) begin
            regs_r[wb_addr] <= wb_data;
        end else begin
            regs_r[wb_addr] <= regs_r[wb_addr];
        end
    end

    // Read muxing, optionally forwarding the writeback data.
    always_comb begin
        rs1_data = regs_r[rs1_idx_s];
        rs2_data = regs_r[rs2_idx_s];
`ifdef FP_REG_BYPASS_EN
        if (wb_en && (wb_addr == rs1_idx_s)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_r[rs1_idx_s];
        end
        if (wb_en && (wb_addr == rs2_idx_s)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_r[rs2_idx_s];
        end
`endif
    end

    fp_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .flush    (flush),
        .rs1_addr (rs1_addr),
        .rs1_use  (rs1_use),
        .rs2_addr (rs2_addr),
        .rs2_use  (rs2_use),
        .stall    (stall),
        .busy_cnt (busy_cnt)
    );

endmodule

// File: doc/fp_regfile.md
FP_REGFILE -- requirements
Module: fp_regfile

Interface
REQ-001 SHALL have parameter FLEN, 32, data width of each FP register (IEEE754 single).
REQ-002 SHALL have parameter NREG, 32, number of FP registers f0..f31; all are writable, with no hardwired zero.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have ports rs1_addr and rs2_addr, input, 5 each, read addresses feeding the FP adder operands A and B.
REQ-006 SHALL have ports rs1_use and rs2_use, input, 1 each, asserted when the decoded op actually reads that source.
REQ-007 SHALL have ports rs1_data and rs2_data, output, FLEN each, read data.
REQ-008 SHALL have ports wb_en (input, 1), wb_addr (input, 5) and wb_data (input, FLEN), the single writeback port carrying the FP adder result.
REQ-009 SHALL have ports iss_en (input, 1) and iss_rd (input, 5), indicating an FP op is issued this cycle that will later write iss_rd.
REQ-010 SHALL have port flush, input, 1, which cancels all in-flight FP ops.
REQ-011 SHALL have port stall, output, 1, a RAW hazard request to hold decode.
REQ-012 SHALL have port busy_cnt, output, 6, the number of registers currently marked busy (0..32).

Function
REQ-013 SHALL make reads combinational (zero latency): rsN_data = reg[rsN_addr], subject to REQ-020.
REQ-014 SHALL perform the write when wb_en=1, so that reg[wb_addr] holds wb_data after the next rising edge; wb_en=0 SHALL leave the array unchanged.
REQ-015 SHALL keep one busy bit per register; iss_en=1 SHALL set busy[iss_rd] at the edge.
REQ-016 SHALL clear busy[wb_addr] at the edge when wb_en=1.
REQ-017 SHALL leave busy set when iss_en and wb_en target the same register in the same cycle (issue wins), because the newer producer is still outstanding.
REQ-018 SHALL, on flush=1, clear every busy bit at the edge; an iss_en in the same cycle SHALL be ignored, while a wb_en in the same cycle SHALL still write the array.
REQ-019 SHALL compute stall = (rs1_use & hazard1) | (rs2_use & hazard2) combinationally, where hazardN = busy[rsN_addr] and not cleared by a same-cycle writeback per REQ-020/REQ-021.
REQ-020 SHALL, when bypass is compiled in, return wb_data on rsN_data when wb_en=1 and wb_addr==rsN_addr, and treat that source as not hazarded.
REQ-021 SHALL, when bypass is compiled out, return the old array value on same-cycle address match and keep hazardN asserted until the cycle after the write.
REQ-022 SHALL keep busy_cnt as a registered population count of the busy bits, updated on the same edge as the bits themselves; it SHALL not wrap because it has 6 bits for a maximum of 32.
REQ-023 SHALL treat an iss_en to a register that is already busy as leaving it busy and busy_cnt unchanged.
REQ-024 SHALL treat a wb_en to a register that is not busy as writing the data and leaving busy_cnt unchanged.

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, clear all registers to 32'h00000000, all busy bits to 0 and busy_cnt to 0; reset SHALL take priority over wb_en, iss_en and flush.
REQ-026 SHALL hold rs1_data=rs2_data=0 and stall=0 after reset until the first write or issue.
REQ-027 SHALL treat reset asserted mid-operation as discarding all pending busy state; no writeback arriving later SHALL decrement busy_cnt below 0.

Configuration
REQ-028 SHALL use macro FP_REG_BYPASS_EN: when defined, the write-to-read bypass of REQ-020 is present; when undefined, behaviour follows REQ-021 and there is no wb_data-to-rsN_data path.

Structure
REQ-029 SHALL place FLEN, NREG, the typedef fp_reg_addr_t (5-bit) and the typedef fp_word_t (FLEN-bit) in shared package fp_pkg.
REQ-030 SHALL implement the busy bits, busy_cnt and the hazard logic in a single sub-module fp_scoreboard, with the register array and read muxing kept in fp_regfile.

Verification
REQ-031 SHALL cover: reset, then read f0 and f31 -> both 0, stall=0, busy_cnt=0.
REQ-032 SHALL cover: iss_en for f5, then a cycle later rs1_addr=5, rs1_use=1 -> stall=1; then wb_en to f5 with data 32'h3F800000 -> with bypass, stall=0 and rs1_data=32'h3F800000 in the same cycle; without bypass, stall=0 and that data appear one cycle later.
REQ-033 SHALL cover: same-cycle iss_en and wb_en both to f7 -> busy[7] stays 1 and busy_cnt is unchanged.
REQ-034 SHALL cover: issue f1, f2 and f3 (busy_cnt=3), then flush together with wb_en to f2 writing 32'h40000000 -> busy_cnt=0 and reg f2=32'h40000000.
REQ-035 SHALL cover: issue all 32 registers -> busy_cnt=32 with no wrap; a repeated iss_en on f0 -> busy_cnt stays 32.
REQ-036 SHALL cover: rst_n=0 with 4 registers busy -> busy_cnt=0, and a subsequent wb_en to one of those registers leaves busy_cnt=0.
